// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM state type and
// fetch-unit defaults. Imported by the fetch unit and the next-PC logic.
package cpu_pkg;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Fetch-unit defaults
    localparam int          DEFAULT_ADDR_W   = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencing: IDLE only after reset, then FETCH <-> ISSUE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

    // Extract the opcode field of an instruction word
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for the current instruction. Pure combinational so the
// multi-cycle controller can reuse it. Priority: jump > branch > fall-through.
// All arithmetic wraps modulo 2^ADDR_W. Jump target needs ADDR_W >= 29.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [31:0]       instr,
    input  logic              jump,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] branch_target;
    logic              unused_opcode;

    // Opcode bits are decoded by the controller, not here
    assign unused_opcode = ^instr[31:26];

    // Region-relative jump: keep the top nibble of pc+4, word-aligned index
    assign jump_target = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};

    // Sign-extended word offset, pre-shifted to a byte offset
    assign branch_off = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

    // Wraps naturally because the sum is truncated to ADDR_W
    assign branch_target = pc_plus4 + branch_off;

    // Redirect priority: jump overrides a simultaneous taken branch
    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = jump_target;
        else if (branch_taken)
            next_pc = branch_target;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory over a req/ready handshake, holds it in the
// instruction register until the datapath retires it, then redirects.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        OP,
    output logic              instr_valid,
    input  logic              instr_accept,
    input  logic              jump,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] next_pc;
    logic              capture;
    logic              retire;

    // A response only counts while a request is outstanding
    assign capture = (state == FETCH) && imem_ready;
    // Accept outside ISSUE is ignored, so it can never move the PC
    assign retire  = (state == ISSUE) && instr_accept;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign imem_addr = pc;

    next_pc_calc #(
        .ADDR_W(ADDR_W)
    ) u_next_pc (
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .jump        (jump),
        .branch_taken(branch_taken),
        .next_pc     (next_pc)
    );

    // State register; async reset kills req/valid in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: one instruction in flight at a time
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (capture) state_nxt = ISSUE;
            ISSUE:   if (retire)  state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; OP is zero whenever no instruction is held
    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == ISSUE);
        OP          = instr_valid ? opcode_of(instr) : 6'd0;
    end

    // PC advances only when the current instruction retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= RESET_PC[ADDR_W-1:0];
        else if (retire)
            pc <= next_pc;
    end

    // Instruction register loads on the handshake and then holds stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr <= 32'd0;
        else if (capture)
            instr <= imem_rdata;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized instruction stream, checked every cycle against a
// transaction-level model of the fetch/retire rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [5:0]  OP;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic        jump = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .OP(OP), .instr_valid(instr_valid),
        .instr_accept(instr_accept), .jump(jump), .branch_taken(branch_taken),
        .pc(pc), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next-PC rule in plain arithmetic
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input bit j, input bit b);
        logic [31:0] p4;
        int off;
        p4 = p + 32'd4;
        if (j) return {p4[31:28], w[25:0], 2'b00};
        if (b) begin
            off = int'($signed(w[15:0]));
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    // Model: waiting for the first post-reset edge, requesting, or holding
    bit          m_started = 1'b0;
    bit          m_req     = 1'b0;
    bit          m_valid   = 1'b0;
    logic [31:0] m_pc      = 32'd0;
    logic [31:0] m_instr   = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_started <= 1'b0; m_req <= 1'b0; m_valid <= 1'b0; m_pc <= 32'd0;
        end else if (!m_started) begin
            m_started <= 1'b1; m_req <= 1'b1;
        end else if (m_req && imem_ready) begin
            m_instr <= imem_rdata; m_req <= 1'b0; m_valid <= 1'b1;
        end else if (m_valid && instr_accept) begin
            m_pc <= model_next(m_pc, m_instr, jump, branch_taken);
            m_valid <= 1'b0; m_req <= 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            if (m_req) chk("imem_addr", imem_addr, m_pc);
            if (m_valid) begin
                chk("instr", instr, m_instr);
                chk("OP", {26'd0, OP}, {26'd0, m_instr[31:26]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, stall dly cycles, then return word w
    task automatic serve(input logic [31:0] w, input int dly);
        int n;
        n = 0;
        while (!imem_req && n < 50) begin tick(); n++; end
        if (!imem_req) begin
            n_checks++; n_fail++;
            $display("FAIL req_timeout: imem_req still 0 after %0d cycles", n);
            return;
        end
        for (int i = 0; i < dly; i++) begin
            imem_ready = 1'b0; imem_rdata = $urandom;
            instr_accept = 1'($urandom_range(0, 1));
            tick();
        end
        instr_accept = 1'b0;
        imem_ready = 1'b1; imem_rdata = w;
        tick();
        imem_ready = 1'b0; imem_rdata = $urandom;
    endtask

    // Hold the instruction dly cycles (redirect noise ignored), then accept
    task automatic retire(input int dly, input bit j, input bit b);
        for (int i = 0; i < dly; i++) begin
            instr_accept = 1'b0;
            jump = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
            imem_ready = 1'($urandom_range(0, 1));
            tick();
        end
        imem_ready = 1'b0;
        instr_accept = 1'b1; jump = j; branch_taken = b;
        tick();
        instr_accept = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Model sanity pins
        chk("model_beq_taken", model_next(32'h10, 32'h1000_FFFF, 0, 1), 32'h10);
        chk("model_jump_prio", model_next(32'h100, 32'h0800_0040, 1, 1), 32'h100);
        chk("model_wrap", model_next(32'hFFFF_FFFC, 32'h0, 0, 0), 32'h0);

        repeat (3) tick();
        armed = 1'b1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_OP", {26'd0, OP}, 32'd0);

        // Release: first edge moves to fetch
        rst = 1'b0;
        tick();
        chk("req_cycle1", {31'd0, imem_req}, 32'd1);
        serve(32'h8C01_0004, 0);
        chk("lw_valid", {31'd0, instr_valid}, 32'd1);
        chk("lw_OP", {26'd0, OP}, 32'h23);
        chk("lw_pc", pc, 32'h0);
        retire(1, 0, 0);
        chk("lw_next_addr", imem_addr, 32'h4);

        // Slow memory: request held for 3 stall cycles (compare process)
        serve(32'h0000_0020, 3);
        retire(0, 0, 0);

        // Jump to 0x10 from pc=8, then BEQ taken/not taken
        serve(32'h0800_0004, 0);
        retire(2, 1, 0);
        chk("j_to_10", pc, 32'h10);
        serve(32'h1000_FFFF, 1);
        retire(0, 0, 1);
        chk("beq_taken", pc, 32'h10);
        serve(32'h1000_FFFF, 0);
        retire(0, 0, 0);
        chk("beq_not_taken", pc, 32'h14);

        // Jump priority over branch
        serve(32'h0800_0040, 0);
        retire(0, 1, 0);
        chk("j_to_100", pc, 32'h100);
        serve(32'h0800_0040, 2);
        retire(1, 1, 1);
        chk("jump_priority", pc, 32'h100);

        // Negative branch to the top of the address space, then wrap
        serve(32'h1000_FFBE, 0);
        retire(0, 0, 1);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        chk("pc_plus4_wrap", pc_plus4, 32'h0);
        serve(32'h0000_0000, 0);
        retire(0, 0, 0);
        chk("wrap_fetch_addr", imem_addr, 32'h0);

        // Randomized instruction stream
        for (int k = 0; k < 40; k++) begin
            serve($urandom, int'($urandom_range(0, 3)));
            retire(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        // Reset mid-FETCH: request drops at once, late response ignored
        serve(32'h1234_5678, 0);
        retire(0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rstf_req", {31'd0, imem_req}, 32'd0);
        chk("rstf_valid", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        tick();
        imem_ready = 1'b0;
        chk("rstf_restart_addr", imem_addr, 32'h0);
        chk("rstf_restart_req", {31'd0, imem_req}, 32'd1);

        // Reset mid-ISSUE: valid drops at once, nothing retired
        serve(32'h0800_0100, 1);
        rst = 1'b1;
        #1;
        chk("rsti_valid", {31'd0, instr_valid}, 32'd0);
        instr_accept = 1'b1; jump = 1'b1;
        tick();
        instr_accept = 1'b0; jump = 1'b0;
        rst = 1'b0;
        tick();
        chk("rsti_pc", pc, 32'h0);
        serve(32'hAC22_0008, 0);
        retire(0, 0, 0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream counterpart of the opcode-decoding main controller in the single-cycle CPU: owns the PC, fetches instruction words from instruction memory over a req/ready handshake, and presents the opcode field OP to the controller.
- Consumes the controller/datapath redirect results (jump, branch-taken) to select the next PC.
- Multi-cycle sequencing: FETCH, then ISSUE; one instruction in flight at a time.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word aligned (bits [1:0] = 0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  fetch address (current PC).
- imem_ready  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  instruction register contents.
- OP  output  6  instr[31:26], driven to the main controller.
- instr_valid  output  1  instr/OP hold a fetched, not-yet-retired instruction.
- instr_accept  input  1  datapath retires the current instruction this cycle.
- jump  input  1  controller JMP for the current instruction.
- branch_taken  input  1  Branch AND ALU zero for the current instruction.
- pc  output  ADDR_W  PC of the current instruction.
- pc_plus4  output  ADDR_W  pc + 4, modulo 2^ADDR_W.

Behaviour:
- Reset (async assert, sync deassert as seen by the FSM): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0. OP=0 during reset, gated by instr_valid=0.
- IDLE: entered only from reset. Moves to FETCH on the first clk edge with rst low.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ready.
  - When imem_ready=1: capture instr<=imem_rdata and move to ISSUE. instr_valid rises in the next cycle.
  - imem_ready while imem_req=0 is ignored.
- ISSUE:
  - imem_req=0, instr_valid=1, instr/OP stable.
  - The unit waits any number of cycles for instr_accept. jump and branch_taken are sampled only on the cycle where instr_accept=1.
  - On accept, pc is loaded with the next PC, instr_valid<=0, and the FSM moves to FETCH.
  - Minimum latency: accept to next imem_req is 1 cycle. A zero-wait-state memory gives 2 cycles per instruction plus the datapath accept delay.
- Next-PC selection, priority order:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch_taken=1: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - else: pc_plus4.
  - jump and branch_taken both 1: jump wins.
- Width and arithmetic:
  - All PC additions wrap modulo 2^ADDR_W. pc=32'hFFFF_FFFC gives pc_plus4=0.
  - Negative branch offsets wrap the same way.
  - pc[1:0] is always 00. The jump target is aligned by construction.
- instr_accept outside ISSUE is ignored. It must not change pc or state.
- Reset mid-FETCH: imem_req drops immediately (asynchronously). The pending response is discarded and fetch restarts from RESET_PC.
- Reset mid-ISSUE: instr_valid drops immediately and the instruction is not retired.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010.
  - Fetch FSM state typedef: IDLE, FETCH, ISSUE.
  - Default RESET_PC.
- One combinational sub-module, next_pc_calc. Inputs: pc_plus4, instr, jump, branch_taken. Output: next_pc. It is reused later by the multi-cycle controller.

Test Plan:
- Reset release, zero-wait memory returning 32'h8C01_0004 (lw) at addr 0 -> imem_req in cycle 1, instr_valid next cycle, OP=6'b100011, pc=0. Accept -> next imem_addr=4.
- Memory ready delayed 3 cycles -> imem_req and imem_addr=pc held for all 3 cycles. No instr_valid until capture.
- BEQ 32'h1000_FFFF at pc=0x10 with branch_taken=1 on accept -> next pc=0x10. With branch_taken=0 -> pc=0x14.
- J 32'h0800_0040 at pc=0x100 with jump=1 and branch_taken=1 on accept -> next pc=0x100 (jump priority).
- pc=32'hFFFF_FFFC, no redirect -> pc_plus4=0 and next fetch at addr 0.
- rst asserted while imem_req=1 -> imem_req=0 and instr_valid=0 the same cycle. A late imem_ready is ignored and the next fetch is at RESET_PC.
